// File: rtl/hilo_unit.sv
// HI/LO register unit: captures ALU MULT/DIV results, commits them after a fixed latency, services MTHI/MTLO/MFHI/MFLO.
// Latency: MULT/DIV commit LATENCY cycles after acceptance; MTHI/MTLO write in 1 cycle; reads are combinational.
// Backpressure: stall is raised while busy and a start or read is presented; the upstream holds the request until idle.
module hilo_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_hilo_start,
    input  logic [1:0]  sig_hilo_op,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        sig_read_hi,
    input  logic        sig_read_lo,
    input  logic        sig_flush,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        busy,
    output logic        stall,
    output logic        div_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    // Countdown reload values; the commit happens on the edge where cnt is already zero.
    localparam logic [7:0] MULT_CNT = 8'(MULT_LATENCY - 1);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_LATENCY - 1);

    state_t      state;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_p;
    logic [31:0] lo_p;
    logic [7:0]  cnt;
    logic        dz_p;
    logic        op_p;
    logic        div_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_p       <= '0;
            lo_p       <= '0;
            cnt        <= '0;
            dz_p       <= 1'b0;
            op_p       <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sig_hilo_start && !sig_flush) begin
                        case (sig_hilo_op)
                            OP_MULT, OP_DIV: begin
                                hi_p  <= alu_hi;
                                lo_p  <= alu_lo;
                                op_p  <= sig_hilo_op[0];
                                cnt   <= sig_hilo_op[0] ? DIV_CNT : MULT_CNT;
                                dz_p  <= sig_hilo_op[0] && (src_b == 32'd0);
                                state <= BUSY;
                            end
                            OP_MTHI: hi_q <= src_a;
                            OP_MTLO: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // Flush wins over a coincident commit.
                    if (sig_flush) begin
                        state <= IDLE;
                    end else if (cnt == 8'd0) begin
                        if (!(op_p && dz_p)) begin
                            hi_q <= hi_p;
                            lo_q <= lo_p;
                        end
                        div_zero_q <= op_p && dz_p;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state == BUSY);
    assign div_zero   = div_zero_q;
    assign read_data  = sig_read_hi ? hi_q : lo_q;
    assign read_valid = (sig_read_hi | sig_read_lo) & ~busy;
    assign stall      = busy & (sig_read_hi | sig_read_lo | sig_hilo_start);

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Execute-stage HI/LO register unit sitting directly downstream of the ALU. It captures the ALU's `hi`/`lo` outputs for MULT/DIV, models their multi-cycle latency with a countdown, and holds the architectural HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads, and raises a pipeline stall while a result is in flight.

## Interface
- `MULT_LATENCY`, default 4: cycles from MULT acceptance to commit; legal range 1..255.
- `DIV_LATENCY`, default 12: cycles from DIV acceptance to commit; legal range 1..255.

- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sig_hilo_start`  in  1  request to start or execute an operation this cycle.
- `sig_hilo_op`  in  2  operation select: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `alu_hi`  in  32  HI result from the ALU, sampled at acceptance.
- `alu_lo`  in  32  LO result from the ALU, sampled at acceptance.
- `src_a`  in  32  write data for MTHI/MTLO.
- `src_b`  in  32  divisor; used only for the divide-by-zero check.
- `sig_read_hi`  in  1  MFHI request.
- `sig_read_lo`  in  1  MFLO request.
- `sig_flush`  in  1  cancel the in-flight op and any start this cycle.
- `read_data`  out  32  HI if `sig_read_hi`, else LO (combinational).
- `read_valid`  out  1  a read is requested and the unit is not busy.
- `busy`  out  1  MULT/DIV in flight.
- `stall`  out  1  hold the pipeline.
- `div_zero`  out  1  one-cycle pulse: a DIV with a zero divisor completed.

## Operation
- **State machine:** IDLE, BUSY. Internal state:
  - `hi_q`, `lo_q`: architectural registers.
  - `hi_p`, `lo_p`: pending result.
  - `cnt`: 8-bit countdown.
  - `dz_p`: pending divide-by-zero flag.
  - `op_p`: 1 bit, MULT or DIV.
- **Acceptance:** a start is accepted only in IDLE with `sig_flush`=0.
- **IDLE, start with MULT/DIV:**
  - Capture `alu_hi`→`hi_p` and `alu_lo`→`lo_p`.
  - Set `cnt` = LATENCY−1 and `dz_p` = (op==DIV && `src_b`==0).
  - Go to BUSY.
- **IDLE, start with MTHI/MTLO:** write `src_a` into `hi_q`/`lo_q` at the edge. State stays IDLE and `busy` is never raised.
- **BUSY, `cnt`≠0:** decrement `cnt`.
- **BUSY, `cnt`==0, commit edge:**
  - If `dz_p`=0: `hi_q`←`hi_p`, `lo_q`←`lo_p`.
  - If `dz_p`=1: `hi_q`/`lo_q` unchanged, and `div_zero`=1 for the following cycle.
  - Go to IDLE.
- **Start while BUSY:** not accepted. `stall`=1 and the upstream holds the request.
- **Flush:**
  - `sig_flush` in BUSY: go to IDLE at the next edge with no commit and no `div_zero`. Flush beats a simultaneous commit.
  - `sig_flush` in IDLE drops a simultaneous start.
- **Reads:**
  - `read_data` = `sig_read_hi` ? `hi_q` : `lo_q`; HI has priority if both read inputs are high.
  - `read_valid` = (`sig_read_hi`|`sig_read_lo`) & ~`busy`.
  - A read in the same cycle as MTHI/MTLO returns the pre-write value.
- **`stall`** = `busy` & (`sig_read_hi` | `sig_read_lo` | `sig_hilo_start`). `stall` is independent of `sig_flush`.
- **Widths:** `cnt` is loaded with the parameter truncated to 8 bits. No arithmetic is done on data; all data paths are 32-bit pass-through.

## Timing
- **Reset** (asynchronous, `rst_n`=0):
  - State IDLE; `hi_q`=`lo_q`=`hi_p`=`lo_p`=0; `cnt`=0; `dz_p`=0.
  - `busy`=0, `stall`=0, `div_zero`=0, `read_valid`=0 (no read asserted).
  - `read_data`=0.
- Reset mid-BUSY aborts the op with no commit.
- **Accepted MULT at edge E0:**
  - `busy`=1 during cycles E0+1 .. E0+L, where L=MULT_LATENCY.
  - The commit occurs at edge E0+L.
  - The new HI/LO is readable, with `read_valid`=1, from cycle E0+L onward.
  - The earliest next start is accepted at edge E0+L+1.
- **Latency 1:** `busy` is high for exactly one cycle.
- **`div_zero`:** high for the single cycle after the commit edge.
- **Back-to-back:** a start in the first IDLE cycle after a commit is accepted with no bubble.
- MTHI/MTLO has a 1-cycle write latency.

## Test plan
- **Reset:** deassert `rst_n`, then read HI and LO → `read_data`=0, `read_valid`=1, `busy`=0.
- **MULT with default latency 4:**
  - Stimulus: `alu_hi`=0x00000001, `alu_lo`=0xFFFFFFFE, `sig_read_hi` held high from the cycle after the start.
  - Required: `busy`/`stall`=1 for 4 cycles with `read_valid`=0; then `read_data`=0x00000001.
  - Then `sig_read_lo` → 0xFFFFFFFE.
- **DIV with `src_b`=0 and default latency 12:**
  - Required: `busy` for 12 cycles, then a `div_zero` pulse for exactly 1 cycle.
  - HI/LO retain their prior values, e.g. 0x12345678/0x9ABCDEF0 written earlier via MTHI/MTLO.
- **Flush:** flush at the 3rd BUSY cycle of a MULT → `busy`=0 next cycle and HI/LO unchanged. A flush coincident with the commit edge also leaves HI/LO unchanged.
- **Start while BUSY:** hold a DIV start during MULT BUSY → `stall`=1 every cycle. The DIV is accepted at the first IDLE edge, and its `busy` window begins the following cycle.
- **MTHI and MFHI in the same cycle:**
  - Stimulus: MTHI with `src_a`=0xCAFEF00D and `sig_read_hi`=1 in the same cycle.
  - Required: the old HI is returned that cycle and 0xCAFEF00D the next cycle; `busy` is never asserted.
